// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash responder: command FSM states, AMD-style
// command bytes and unlock addresses.
package nor_flash_pkg;

  typedef enum logic [3:0] {
    StRdArray,
    StUnlk1,
    StUnlk2,
    StPrgData,
    StEra80,
    StEraAa,
    StEra55,
    StAutosel,
    StBusyPrg,
    StBusyEra
  } state_e;

  localparam logic [7:0] CmdAa = 8'hAA;
  localparam logic [7:0] Cmd55 = 8'h55;
  localparam logic [7:0] CmdA0 = 8'hA0;
  localparam logic [7:0] Cmd80 = 8'h80;
  localparam logic [7:0] Cmd90 = 8'h90;
  localparam logic [7:0] Cmd30 = 8'h30;
  localparam logic [7:0] Cmd50 = 8'h50;
  localparam logic [7:0] Cmd10 = 8'h10;
  localparam logic [7:0] CmdF0 = 8'hF0;

  localparam logic [11:0] AddrAaa = 12'hAAA;
  localparam logic [11:0] Addr555 = 12'h555;

  // True when a bus write carries command byte cd at unlock address ca.
  function automatic logic is_cmd(input logic [7:0]  d, input logic [11:0] a,
                                  input logic [7:0] cd, input logic [11:0] ca);
    return (d == cd) && (a == ca);
  endfunction

endpackage

// File: rtl/nor_flash_ram.sv
// Single-port byte RAM backing the emulated flash array; 1-cycle read latency.
// Contents are deliberately not reset.
module nor_flash_ram #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              iCLK,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**MEM_AW];

  // Synchronous write and registered read on the shared port.
  always_ff @(posedge iCLK) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/nor_flash_responder.sv
// Byte-wide NOR flash responder: decodes unlock/command writes, backs them with
// an on-chip array, and returns array, autoselect or busy data on FL_DQ.
// Optional build macro NOR_RESP_STATUS_EN: busy reads return {~D7, toggle, 6'b0}
// instead of 8'hFF.
module nor_flash_responder
  import nor_flash_pkg::*;
#(
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned SEC_AW  = 8,
  parameter int unsigned BLK_AW  = 10,
  parameter int unsigned PRG_CYC = 6,
  parameter logic [7:0]  MFR_ID  = 8'h01,
  parameter logic [7:0]  DEV_ID  = 8'h5B
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [19:0] FL_ADDR,
  inout  wire  [7:0]  FL_DQ,
  input  logic        FL_WE_n,
  input  logic        FL_CE_n,
  input  logic        FL_OE_n,
  input  logic        FL_RST_n,
  output logic        oBusy
);

  localparam int unsigned PrgCntW = (PRG_CYC > 1) ? $clog2(PRG_CYC) : 1;
  localparam logic [MEM_AW-1:0] AllMask = {MEM_AW{1'b1}};
  localparam logic [MEM_AW-1:0] SecMask = AllMask >> (MEM_AW - SEC_AW);
  localparam logic [MEM_AW-1:0] BlkMask = AllMask >> (MEM_AW - BLK_AW);

  // Two-flop synchronizers; every bus input has the same depth.
  logic [19:0] addr_meta_q, addr_sync_q;
  logic [7:0]  dq_meta_q, dq_sync_q;
  logic        we_meta_q, we_sync_q, we_prev_q;
  logic        ce_meta_q, ce_sync_q;
  logic        oe_meta_q, oe_sync_q;
  logic        frst_meta_q, frst_sync_q;

  state_e state_q, state_d;

  logic [1:0]         prg_phase_q;
  logic [MEM_AW-1:0]  prg_addr_q;
  logic [7:0]         prg_data_q;
  logic [PrgCntW-1:0] prg_cnt_q;
  logic [MEM_AW-1:0]  era_base_q, era_mask_q, era_cnt_q;
  logic [MEM_AW-1:0]  rd_addr_q;
  logic [7:0]         dq_q, dq_d;
  logic               dq_oe;

  logic              ram_we;
  logic [MEM_AW-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;

  logic              wr_ev, era_done, busy;
  logic [7:0]        cmd;
  logic [11:0]       a12;
  logic [MEM_AW-1:0] mem_addr;
  logic              unused_addr;

  assign cmd         = dq_sync_q;
  assign a12         = addr_sync_q[11:0];
  assign mem_addr    = addr_sync_q[MEM_AW-1:0];
  assign unused_addr = ^addr_sync_q;
  assign wr_ev       = we_sync_q & ~we_prev_q & ~ce_sync_q & oe_sync_q;
  assign era_done    = (era_cnt_q & era_mask_q) == era_mask_q;
  assign busy        = (state_q == StBusyPrg) || (state_q == StBusyEra);

  // Bus input synchronizers plus the WE_n edge-detect stage.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_meta_q <= '0;
      addr_sync_q <= '0;
      dq_meta_q   <= '0;
      dq_sync_q   <= '0;
      we_meta_q   <= 1'b1;
      we_sync_q   <= 1'b1;
      we_prev_q   <= 1'b1;
      ce_meta_q   <= 1'b1;
      ce_sync_q   <= 1'b1;
      oe_meta_q   <= 1'b1;
      oe_sync_q   <= 1'b1;
      frst_meta_q <= 1'b0;
      frst_sync_q <= 1'b0;
    end else begin
      addr_meta_q <= FL_ADDR;
      addr_sync_q <= addr_meta_q;
      dq_meta_q   <= FL_DQ;
      dq_sync_q   <= dq_meta_q;
      we_meta_q   <= FL_WE_n;
      we_sync_q   <= we_meta_q;
      we_prev_q   <= we_sync_q;
      ce_meta_q   <= FL_CE_n;
      ce_sync_q   <= ce_meta_q;
      oe_meta_q   <= FL_OE_n;
      oe_sync_q   <= oe_meta_q;
      frst_meta_q <= FL_RST_n;
      frst_sync_q <= frst_meta_q;
    end
  end

  // Command FSM state register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= StRdArray;
    else         state_q <= state_d;
  end

  // Command FSM next-state decode.
  always_comb begin
    state_d = state_q;
    if (!frst_sync_q) begin
      state_d = StRdArray;
    end else begin
      unique case (state_q)
        StRdArray: if (wr_ev && is_cmd(cmd, a12, CmdAa, AddrAaa)) state_d = StUnlk1;
        StUnlk1: begin
          if (wr_ev) state_d = is_cmd(cmd, a12, Cmd55, Addr555) ? StUnlk2 : StRdArray;
        end
        StUnlk2: begin
          if (wr_ev) begin
            if      (is_cmd(cmd, a12, CmdA0, AddrAaa)) state_d = StPrgData;
            else if (is_cmd(cmd, a12, Cmd80, AddrAaa)) state_d = StEra80;
            else if (is_cmd(cmd, a12, Cmd90, AddrAaa)) state_d = StAutosel;
            else                                       state_d = StRdArray;
          end
        end
        StPrgData: if (prg_phase_q == 2'd2) state_d = StBusyPrg;
        StEra80: begin
          if (wr_ev) state_d = is_cmd(cmd, a12, CmdAa, AddrAaa) ? StEraAa : StRdArray;
        end
        StEraAa: begin
          if (wr_ev) state_d = is_cmd(cmd, a12, Cmd55, Addr555) ? StEra55 : StRdArray;
        end
        StEra55: begin
          if (wr_ev) begin
            if (cmd == Cmd30 || cmd == Cmd50 || is_cmd(cmd, a12, Cmd10, AddrAaa)) begin
              state_d = StBusyEra;
            end else begin
              state_d = StRdArray;
            end
          end
        end
        StAutosel: if (wr_ev && cmd == CmdF0) state_d = StRdArray;
        StBusyPrg: if (prg_cnt_q == '0) state_d = StRdArray;
        StBusyEra: if (era_done) state_d = StRdArray;
        default:   state_d = StRdArray;
      endcase
    end
  end

  // Program/erase bookkeeping and the read output register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      prg_phase_q <= 2'd0;
      prg_addr_q  <= '0;
      prg_data_q  <= '0;
      prg_cnt_q   <= '0;
      era_base_q  <= '0;
      era_mask_q  <= '0;
      era_cnt_q   <= '0;
      rd_addr_q   <= '0;
      dq_q        <= '0;
    end else begin
      rd_addr_q <= mem_addr;
      dq_q      <= dq_d;
      // Phase 1 reads the old byte, phase 2 writes old AND new.
      if (state_q == StPrgData && frst_sync_q) begin
        case (prg_phase_q)
          2'd0: begin
            if (wr_ev) begin
              prg_addr_q  <= mem_addr;
              prg_data_q  <= cmd;
              prg_phase_q <= 2'd1;
            end
          end
          2'd1:    prg_phase_q <= 2'd2;
          default: prg_phase_q <= 2'd0;
        endcase
      end else begin
        prg_phase_q <= 2'd0;
      end
      if (state_q != StBusyPrg && state_d == StBusyPrg) begin
        prg_cnt_q <= PrgCntW'(PRG_CYC - 1);
      end else if (state_q == StBusyPrg) begin
        prg_cnt_q <= prg_cnt_q - 1'b1;
      end
      if (state_q == StEra55 && state_d == StBusyEra) begin
        era_base_q <= mem_addr;
        era_cnt_q  <= '0;
        if      (cmd == Cmd30) era_mask_q <= SecMask;
        else if (cmd == Cmd50) era_mask_q <= BlkMask;
        else                   era_mask_q <= AllMask;
      end else if (state_q == StBusyEra) begin
        era_cnt_q <= era_cnt_q + 1'b1;
      end
    end
  end

`ifdef NOR_RESP_STATUS_EN
  logic oe_prev_q, toggle_q, d7;
  assign d7 = (state_q == StBusyPrg) & prg_data_q[7];

  // Toggle bit flips on every synchronized OE_n falling edge.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oe_prev_q <= 1'b1;
      toggle_q  <= 1'b0;
    end else begin
      oe_prev_q <= oe_sync_q;
      if (oe_prev_q && !oe_sync_q) toggle_q <= ~toggle_q;
    end
  end
`endif

  // RAM port arbitration, read data selection and bus drive enable.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = mem_addr;
    ram_wdata = 8'hFF;
    if (state_q == StBusyEra) begin
      ram_addr = (era_base_q & ~era_mask_q) | (era_cnt_q & era_mask_q);
      ram_we   = frst_sync_q;
    end else if (state_q == StPrgData && prg_phase_q != 2'd0) begin
      ram_addr  = prg_addr_q;
      ram_wdata = ram_rdata & prg_data_q;
      ram_we    = (prg_phase_q == 2'd2) && frst_sync_q;
    end

    if (busy) begin
`ifdef NOR_RESP_STATUS_EN
      dq_d = {~d7, toggle_q, 6'b0};
`else
      dq_d = 8'hFF;
`endif
    end else if (state_q == StAutosel) begin
      if      (rd_addr_q == MEM_AW'(0)) dq_d = MFR_ID;
      else if (rd_addr_q == MEM_AW'(2)) dq_d = DEV_ID;
      else                              dq_d = 8'h00;
    end else begin
      dq_d = ram_rdata;
    end

    oBusy = busy;
    dq_oe = ~ce_sync_q & ~oe_sync_q & frst_sync_q;
  end

  assign FL_DQ = dq_oe ? dq_q : 8'bz;

  nor_flash_ram #(
    .MEM_AW(MEM_AW)
  ) u_ram (
    .iCLK  (iCLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_nor_flash_responder.sv
// Directed bench for nor_flash_responder: bus-level writes/reads with a scoreboard
// of expected read bytes checked through immediate assertions.
module tb_nor_flash_responder;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic [19:0] FL_ADDR;
  wire  [7:0]  FL_DQ;
  logic        FL_WE_n, FL_CE_n, FL_OE_n, FL_RST_n;
  logic        oBusy;

  logic [7:0]  tb_dq;
  logic        tb_dq_en;

  int          checks = 0;
  int          errors = 0;
  int          oe_falls = 0;
  int          busy_total = 0;
  int          busy_start;
  logic [7:0]  sb[$];
  logic [7:0]  last_rd;

  always #5 iCLK = ~iCLK;

  assign FL_DQ = tb_dq_en ? tb_dq : 8'bz;

  // Weak pull so an undriven bus reads as 8'hFF.
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (FL_DQ[g]);
  end

  always @(negedge iCLK) if (oBusy) busy_total <= busy_total + 1;

  nor_flash_responder dut (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .FL_ADDR  (FL_ADDR),
    .FL_DQ    (FL_DQ),
    .FL_WE_n  (FL_WE_n),
    .FL_CE_n  (FL_CE_n),
    .FL_OE_n  (FL_OE_n),
    .FL_RST_n (FL_RST_n),
    .oBusy    (oBusy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge iCLK);
    FL_ADDR  = {8'h3C, a};
    tb_dq    = d;
    tb_dq_en = 1'b1;
    FL_CE_n  = 1'b0;
    FL_WE_n  = 1'b0;
    repeat (4) @(negedge iCLK);
    FL_WE_n = 1'b1;
    repeat (4) @(negedge iCLK);
    FL_CE_n  = 1'b1;
    tb_dq_en = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [7:0] e, input string tag);
    logic [7:0] exp;
    @(negedge iCLK);
    FL_ADDR = {8'h00, a};
    FL_CE_n = 1'b0;
    FL_OE_n = 1'b0;
    oe_falls++;
    sb.push_back(e);
    repeat (6) @(negedge iCLK);
    last_rd = FL_DQ;
    exp = sb.pop_front();
    check(tag, last_rd, exp);
    FL_CE_n = 1'b1;
    FL_OE_n = 1'b1;
    repeat (3) @(negedge iCLK);
  endtask

  task automatic wait_idle();
    repeat (8) @(negedge iCLK);
    for (int i = 0; i < 20000 && oBusy; i++) @(negedge iCLK);
    check("idle_timeout", oBusy, 0);
    repeat (2) @(negedge iCLK);
  endtask

  task automatic prog(input logic [11:0] a, input logic [7:0] d);
    wr(12'hAAA, 8'hAA);
    wr(12'h555, 8'h55);
    wr(12'hAAA, 8'hA0);
    busy_start = busy_total;
    wr(a, d);
    wait_idle();
    check("prg_busy_len", busy_total - busy_start, 6);
  endtask

  task automatic erase(input logic [7:0] c, input logic [11:0] a);
    wr(12'hAAA, 8'hAA);
    wr(12'h555, 8'h55);
    wr(12'hAAA, 8'h80);
    wr(12'hAAA, 8'hAA);
    wr(12'h555, 8'h55);
    busy_start = busy_total;
    wr(a, c);
  endtask

  // Expected busy-time read byte for the next read.
  function automatic logic [7:0] status_next();
`ifdef NOR_RESP_STATUS_EN
    logic [31:0] n;
    n = oe_falls + 1;
    return {1'b1, n[0], 6'b0};
`else
    return 8'hFF;
`endif
  endfunction

  initial begin
    logic [7:0] st1, st2;
    int n;
    iRST_n   = 1'b0;
    FL_ADDR  = '0;
    FL_WE_n  = 1'b1;
    FL_CE_n  = 1'b0;
    FL_OE_n  = 1'b0;
    FL_RST_n = 1'b1;
    tb_dq    = '0;
    tb_dq_en = 1'b0;
    repeat (4) @(negedge iCLK);
    check("reset_dq_hiz", FL_DQ, 8'hFF);
    check("reset_busy", oBusy, 0);
    FL_CE_n = 1'b1;
    FL_OE_n = 1'b1;
    @(negedge iCLK);
    iRST_n = 1'b1;
    repeat (4) @(negedge iCLK);
    check("idle_busy", oBusy, 0);

    // Chip erase
    erase(8'h10, 12'hAAA);
    wait_idle();
    check("chip_busy_len", busy_total - busy_start, 4096);
    rd(12'h000, 8'hFF, "chip_000");
    rd(12'h123, 8'hFF, "chip_123");
    rd(12'hFFF, 8'hFF, "chip_fff");

    // Program: bits only clear
    prog(12'h123, 8'h3C);
    rd(12'h123, 8'h3C, "prg_3c");
    prog(12'h123, 8'hF0);
    rd(12'h123, 8'h30, "prg_and");
    prog(12'h200, 8'h55);
    prog(12'h400, 8'h5A);

    // Sector erase with busy-time reads
    erase(8'h30, 12'h123);
    st1 = status_next();
    rd(12'h123, st1, "status_rd1");
    st1 = last_rd;
    st2 = status_next();
    rd(12'h123, st2, "status_rd2");
    st2 = last_rd;
`ifdef NOR_RESP_STATUS_EN
    check("status_toggle", st1[6] ^ st2[6], 1);
`endif
    wait_idle();
    check("sec_busy_len", busy_total - busy_start, 256);
    rd(12'h123, 8'hFF, "sec_inside");
    rd(12'h1FF, 8'hFF, "sec_top");
    rd(12'h200, 8'h55, "sec_outside");
    prog(12'h010, 8'h3C);
    rd(12'h010, 8'h3C, "prg_010");

    // Block erase
    erase(8'h50, 12'h000);
    wait_idle();
    check("blk_busy_len", busy_total - busy_start, 1024);
    rd(12'h200, 8'hFF, "blk_inside");
    rd(12'h010, 8'hFF, "blk_010");
    rd(12'h400, 8'h5A, "blk_outside");

    // Autoselect
    wr(12'hAAA, 8'hAA);
    wr(12'h555, 8'h55);
    wr(12'hAAA, 8'h90);
    rd(12'h000, 8'h01, "asel_mfr");
    rd(12'h002, 8'h5B, "asel_dev");
    rd(12'h001, 8'h00, "asel_other");
    wr(12'h000, 8'hF0);
    rd(12'h400, 8'h5A, "asel_exit");

    // Broken unlock, then a bare write must not program
    prog(12'h020, 8'h81);
    wr(12'hAAA, 8'hAA);
    wr(12'h555, 8'h11);
    busy_start = busy_total;
    wr(12'h020, 8'h77);
    repeat (12) @(negedge iCLK);
    check("bare_no_busy", busy_total - busy_start, 0);
    rd(12'h020, 8'h81, "bare_unchanged");

    // Bus reset mid sector erase
    prog(12'h300, 8'h00);
    prog(12'h3F0, 8'h0F);
    erase(8'h30, 12'h300);
    repeat (40) @(negedge iCLK);
    check("abort_busy_pre", oBusy, 1);
    FL_RST_n = 1'b0;
    n = 0;
    while (oBusy && n < 10) begin
      @(negedge iCLK);
      n++;
    end
    check("abort_latency_le3", (n <= 3) ? 1 : 0, 1);
    FL_ADDR = {8'h00, 12'h3F0};
    FL_CE_n = 1'b0;
    FL_OE_n = 1'b0;
    oe_falls++;
    repeat (6) @(negedge iCLK);
    check("rst_dq_hiz", FL_DQ, 8'hFF);
    FL_CE_n = 1'b1;
    FL_OE_n = 1'b1;
    repeat (4) @(negedge iCLK);
    FL_RST_n = 1'b1;
    repeat (4) @(negedge iCLK);
    rd(12'h300, 8'hFF, "abort_erased");
    rd(12'h3F0, 8'h0F, "abort_untouched");
    prog(12'h3F0, 8'h3C);
    rd(12'h3F0, 8'h0C, "abort_then_prg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
